// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, requester FSM states and timeout default
package apb_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int APB_TIMEOUT_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_req_state_e;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: byte address to one-hot completer select plus decode-error flag
module apb_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int SLV_NUM = 4,
  parameter int SEL_LSB = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SLV_NUM-1:0]    sel,
  output logic                  err
);
  localparam int IW = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  logic [IW-1:0] idx;
  logic unused_addr;
  assign idx = addr[SEL_LSB +: IW];
  assign err = (int'(idx) >= SLV_NUM) || (addr[1:0] != 2'b00);
  assign sel = err ? '0 : (SLV_NUM'(1) << idx);
  assign unused_addr = ^addr;
endmodule

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding valid/ready command to APB transfer bridge with timeout
module apb_requester #(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int SLV_NUM = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = apb_pkg::APB_TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [SLV_NUM-1:0]    PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);
  import apb_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  apb_req_state_e state;
  logic [CW-1:0] cnt;
  logic [SLV_NUM-1:0] dec_sel;
  logic dec_err;
  apb_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .SLV_NUM(SLV_NUM), .SEL_LSB(SEL_LSB)) u_dec (
    .addr(cmd_addr),
    .sel (dec_sel),
    .err (dec_err)
  );
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (dec_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= SETUP;
              cmd_ready <= 1'b0;
              cnt       <= '0;
              PSEL      <= dec_sel;
              PADDR     <= cmd_addr;
              PWRITE    <= cmd_write;
              PWDATA    <= cmd_wdata;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          // z/x on PREADY never compares equal to 1, so it reads as not ready
          if (PREADY == 1'b1 || cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= !(PREADY == 1'b1);
            rsp_rdata <= (PREADY == 1'b1 && !PWRITE) ? PRDATA : '0;
          end else
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: scoreboard bench for apb_requester against a one-wait-state completer model
module tb_apb_requester;
  typedef struct packed {logic err; logic [31:0] rdata; logic [31:0] cyc;} rsp_t;
  logic PCLK = 1'b0;
  logic PRESET, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_err;
  logic PWRITE, PENABLE, PREADY, pready_r, no_ready;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, PADDR, PWDATA, PRDATA;
  logic [3:0] PSEL;
  logic [3:0] prev_psel = '0;
  logic [1:0] sidx;
  logic [31:0] mem [0:4095];
  int cyc, tests, failed, rd, proto_err, en_run, en_last;
  rsp_t obs_q[$], exp_q[$];
  logic [3:0] psel_log[$];

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_NUM(4), .SEL_LSB(12), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // completer: registered PREADY one cycle after PSEL&PENABLE, word memory per slave
  assign sidx   = {PSEL[3] | PSEL[2], PSEL[3] | PSEL[1]};
  assign PREADY = pready_r;
  assign PRDATA = mem[{sidx, PADDR[11:2]}];
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) pready_r <= 1'b0;
    else pready_r <= (|PSEL) && PENABLE && !pready_r && !no_ready;
  always @(posedge PCLK)
    if (pready_r && PENABLE && PWRITE) mem[{sidx, PADDR[11:2]}] <= PWDATA;

  always @(negedge PCLK) begin
    if (rsp_valid) obs_q.push_back({rsp_err, rsp_rdata, 32'(cyc)});
    if (PENABLE && PSEL == 4'b0) proto_err++;
    if (PSEL != 4'b0 && !$onehot(PSEL)) proto_err++;
    if (PSEL != 4'b0 && prev_psel == 4'b0) begin
      psel_log.push_back(PSEL);
      if (PENABLE) proto_err++;
    end
    if (PSEL != 4'b0 && prev_psel != 4'b0 && PSEL != prev_psel) proto_err++;
    if (PENABLE) en_run++;
    else if (en_run != 0) begin
      en_last = en_run;
      en_run = 0;
    end
    prev_psel = PSEL;
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic e,
                      input logic [31:0] r, input int lat, input bit push, input bit hold);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge PCLK);
    if (push) exp_q.push_back({e, r, 32'(cyc + lat)});
    @(posedge PCLK); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; no_ready = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    tests++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== '0) begin
      failed++;
      $display("FAIL reset_values: PSEL=%b EN=%b PADDR=%h PWRITE=%b PWDATA=%h rv=%b re=%b rd=%h rdy=%b, want all 0",
               PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
    end
    PRESET = 1'b1;
    #1 tests++;
    if (cmd_ready !== 1'b0) begin failed++; $display("FAIL reset_rdy_before_edge: got %b want 0", cmd_ready); end
    @(posedge PCLK); #1 tests++;
    if (cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_rdy_first_edge: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_read();
    int n0 = psel_log.size();
    logic [31:0] d = $urandom;
    send(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 32'h0, 4, 1'b1, 1'b0);
    send(1'b0, 32'h0000_1008, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1, 1'b0);
    send(1'b1, 32'h0000_3010, d, 1'b0, 32'h0, 4, 1'b1, 1'b0);
    send(1'b0, 32'h0000_3010, 32'h0, 1'b0, d, 4, 1'b1, 1'b0);
    for (int i = 0; i < 60 && obs_q.size() - rd < exp_q.size(); i++) @(posedge PCLK);
    repeat (3) @(posedge PCLK);
    tests++;
    if (obs_q.size() - rd !== exp_q.size()) begin
      failed++; $display("FAIL wr_rd rsp_count: got %0d want %0d", obs_q.size() - rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (obs_q[rd+i] !== exp_q[i]) begin
        failed++;
        $display("FAIL wr_rd rsp[%0d]: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d", i,
                 obs_q[rd+i].err, obs_q[rd+i].rdata, obs_q[rd+i].cyc, exp_q[i].err, exp_q[i].rdata, exp_q[i].cyc);
      end
    end
    rd = obs_q.size(); exp_q.delete();
    tests++;
    if (psel_log.size() - n0 !== 4 || psel_log[n0] !== 4'b0010 || psel_log[n0+1] !== 4'b0010 ||
        psel_log[n0+2] !== 4'b1000) begin
      failed++; $display("FAIL wr_rd psel: got %0d transfers first=%b, want 4 with 0010,0010,1000",
                         psel_log.size() - n0, psel_log[n0]);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = psel_log.size();
    for (int s = 0; s < 4; s++)
      send(1'b1, 32'(s) << 12 | 32'h10, $urandom, 1'b0, 32'h0, 4, 1'b1, s != 3);
    for (int i = 0; i < 60 && obs_q.size() - rd < exp_q.size(); i++) @(posedge PCLK);
    repeat (3) @(posedge PCLK);
    tests++;
    if (obs_q.size() - rd !== exp_q.size()) begin
      failed++; $display("FAIL b2b rsp_count: got %0d want %0d", obs_q.size() - rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (obs_q[rd+i] !== exp_q[i]) begin
        failed++;
        $display("FAIL b2b rsp[%0d]: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d", i,
                 obs_q[rd+i].err, obs_q[rd+i].rdata, obs_q[rd+i].cyc, exp_q[i].err, exp_q[i].rdata, exp_q[i].cyc);
      end
    end
    rd = obs_q.size(); exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      tests++;
      if (psel_log[n0+s] !== 4'(1 << s)) begin
        failed++; $display("FAIL b2b psel[%0d]: got %b want %b", s, psel_log[n0+s], 4'(1 << s));
      end
    end
    tests++;
    if (proto_err !== 0) begin failed++; $display("FAIL b2b protocol: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_decode_error();
    int n0 = psel_log.size();
    send(1'b0, 32'h0000_1002, 32'h0, 1'b1, 32'h0, 1, 1'b1, 1'b0);
    @(negedge PCLK);
    tests++;
    if (cmd_ready !== 1'b1) begin failed++; $display("FAIL dec_err cmd_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < 60 && obs_q.size() - rd < exp_q.size(); i++) @(posedge PCLK);
    repeat (3) @(posedge PCLK);
    tests++;
    if (obs_q.size() - rd !== exp_q.size()) begin
      failed++; $display("FAIL dec_err rsp_count: got %0d want %0d", obs_q.size() - rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (obs_q[rd+i] !== exp_q[i]) begin
        failed++;
        $display("FAIL dec_err rsp: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d",
                 obs_q[rd+i].err, obs_q[rd+i].rdata, obs_q[rd+i].cyc, exp_q[i].err, exp_q[i].rdata, exp_q[i].cyc);
      end
    end
    rd = obs_q.size(); exp_q.delete();
    tests++;
    if (psel_log.size() !== n0) begin failed++; $display("FAIL dec_err psel_activity: got %0d transfers want 0", psel_log.size() - n0); end
  endtask

  task automatic test_timeout();
    no_ready = 1'b1;
    send(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 18, 1'b1, 1'b0);
    for (int i = 0; i < 60 && obs_q.size() - rd < exp_q.size(); i++) @(posedge PCLK);
    repeat (3) @(posedge PCLK);
    tests++;
    if (obs_q.size() - rd !== exp_q.size()) begin
      failed++; $display("FAIL timeout rsp_count: got %0d want %0d", obs_q.size() - rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (obs_q[rd+i] !== exp_q[i]) begin
        failed++;
        $display("FAIL timeout rsp: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d",
                 obs_q[rd+i].err, obs_q[rd+i].rdata, obs_q[rd+i].cyc, exp_q[i].err, exp_q[i].rdata, exp_q[i].cyc);
      end
    end
    rd = obs_q.size(); exp_q.delete();
    tests++;
    if (en_last !== 16) begin failed++; $display("FAIL timeout penable_len: got %0d want 16", en_last); end
    tests++;
    if (PSEL !== 4'b0) begin failed++; $display("FAIL timeout psel_after: got %b want 0000", PSEL); end
    no_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    send(1'b0, 32'h0000_1008, 32'h0, 1'b0, 32'h0, 4, 1'b0, 1'b0);
    @(posedge PCLK); #1 tests++;
    if (PENABLE !== 1'b1) begin failed++; $display("FAIL rst_mid in_access: got PENABLE=%b want 1", PENABLE); end
    PRESET = 1'b0;
    #1 tests++;
    if ({PSEL, PENABLE, rsp_valid} !== 6'b0) begin
      failed++; $display("FAIL rst_mid async_drop: got PSEL=%b EN=%b rv=%b want 0", PSEL, PENABLE, rsp_valid);
    end
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK); #1 tests++;
    if (cmd_ready !== 1'b1) begin failed++; $display("FAIL rst_mid rdy_first_edge: got %b want 1", cmd_ready); end
    send(1'b0, 32'h0000_1008, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1, 1'b0);
    for (int i = 0; i < 60 && obs_q.size() - rd < exp_q.size(); i++) @(posedge PCLK);
    repeat (3) @(posedge PCLK);
    tests++;
    if (obs_q.size() - rd !== exp_q.size()) begin
      failed++; $display("FAIL rst_mid rsp_count: got %0d want %0d", obs_q.size() - rd, exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (obs_q[rd+i] !== exp_q[i]) begin
        failed++;
        $display("FAIL rst_mid rsp: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d",
                 obs_q[rd+i].err, obs_q[rd+i].rdata, obs_q[rd+i].cyc, exp_q[i].err, exp_q[i].rdata, exp_q[i].cyc);
      end
    end
    rd = obs_q.size(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_decode_error();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
